// File: rtl/neuron_mac.sv
// neuron_mac: weighted-sum stage ahead of the sigmoid activation.
// Accumulates N_INPUTS signed Q4.4 x*w products plus a Q4.4 bias at full
// precision (Q8.8 in a 20-bit accumulator). It then floors the sum to Q4.4
// and saturates it to 8 bits.
//
// Handshake: a pair transfers on a rising edge where in_valid && in_ready.
// A result transfers on a rising edge where out_valid && out_ready. A
// producer may hold in_valid and change data freely while in_ready is low;
// nothing is sampled then. out_valid and in_ready are never high together.
module neuron_mac #(
   parameter int N_INPUTS = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] x_in,
   input  logic [7:0] w_in,
   input  logic [7:0] bias,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] z,
   output logic       sat,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   localparam logic [4:0] N_LAST = 5'(N_INPUTS);

   state_t             state;
   state_t             state_next;
   logic signed [19:0] acc;
   logic [4:0]         cnt;

   logic               take;
   logic               last;
   logic signed [15:0] prod;
   logic signed [19:0] prod_ext;
   logic signed [19:0] bias_ext;
   logic signed [19:0] sum_next;
   logic signed [19:0] floor_sum;
   logic [7:0]         z_next;
   logic               sat_next;

   assign dbg_state = state;
   assign take      = in_valid && in_ready;

   // Full-precision product and the running sum after this pair.
   always_comb begin
      prod      = $signed(x_in) * $signed(w_in);
      prod_ext  = {{4{prod[15]}}, prod};
      bias_ext  = {{8{bias[7]}}, bias, 4'b0000};
      if (state == IDLE) begin
         sum_next = bias_ext + prod_ext;
         last     = (N_INPUTS == 1);
      end else begin
         sum_next = acc + prod_ext;
         last     = ((cnt + 5'd1) == N_LAST);
      end
   end

   // Floor to Q4.4 and saturate into the signed 8-bit range.
   always_comb begin
      floor_sum = sum_next >>> 4;
      z_next    = floor_sum[7:0];
      sat_next  = 1'b0;
      if (floor_sum > 20'sd127) begin
         z_next   = 8'h7F;
         sat_next = 1'b1;
      end else if (floor_sum < -20'sd128) begin
         z_next   = 8'h80;
         sat_next = 1'b1;
      end
   end

   // Next-state logic for the IDLE -> ACC -> OUT neuron sequence.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (take) state_next = last ? OUT : ACC;
         end
         ACC: begin
            if (take && last) state_next = OUT;
         end
         OUT: begin
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // State register. The handshake flags are registered so that both stay
   // low while reset is asserted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_next;
         in_ready  <= (state_next != OUT);
         out_valid <= (state_next == OUT);
      end
   end

   // Accumulator, pair counter and the result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         cnt <= '0;
         z   <= '0;
         sat <= 1'b0;
      end else if (take) begin
         acc <= sum_next;
         cnt <= (state == IDLE) ? 5'd1 : cnt + 5'd1;
         if (last) begin
            z   <= z_next;
            sat <= sat_next;
         end
      end
   end

endmodule

// File: tb/tb_neuron_mac.sv
// Directed testbench for neuron_mac (N_INPUTS = 4).
// Inputs are driven and outputs are sampled on the falling clock edge.
module tb_neuron_mac;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] x_in;
   logic [7:0] w_in;
   logic [7:0] bias;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] z;
   logic       sat;
   logic [1:0] dbg_state;

   int tests;
   int fails;
   int cyc;
   int t0;

   neuron_mac #(.N_INPUTS(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x_in      (x_in),
      .w_in      (w_in),
      .bias      (bias),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .z         (z),
      .sat       (sat),
      .dbg_state (dbg_state)
   );

   // Clock and cycle counter.
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present a pair from a falling edge and wait for its accepting edge.
   // The task returns at the falling edge after that edge.
   task automatic push(input logic [7:0] x, input logic [7:0] w, input logic [7:0] b);
      int n;
      x_in = x; w_in = w; bias = b; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         tests++;
         fails++;
         $error("FAIL push_timeout observed=0 expected=1");
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic push4(input logic [7:0] x, input logic [7:0] w, input logic [7:0] b);
      for (int i = 0; i < 4; i++) push(x, w, b);
   endtask

   task automatic check_result(input string tag, input logic [7:0] ez, input logic es);
      check({tag, "_valid"}, {7'd0, out_valid}, 8'h01);
      check({tag, "_z"}, z, ez);
      check({tag, "_sat"}, {7'd0, sat}, {7'd0, es});
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   initial begin
      tests = 0; fails = 0; cyc = 0;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      x_in = 8'h00; w_in = 8'h00; bias = 8'h00;

      // Reset state.
      idle_cycles(2);
      check("rst_in_ready", {7'd0, in_ready}, 8'h00);
      check("rst_out_valid", {7'd0, out_valid}, 8'h00);
      check("rst_z", z, 8'h00);
      check("rst_sat", {7'd0, sat}, 8'h00);
      check("rst_state", {6'd0, dbg_state}, 8'h00);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", {7'd0, in_ready}, 8'h01);

      // Basic sum 4 * 1.0 * 0.5 = 2.0, measure latency back-to-back.
      t0 = cyc;
      push4(8'h10, 8'h08, 8'h00);
      check_result("basic", 8'h20, 1'b0);
      check("basic_latency", 8'(cyc - t0), 8'd4);
      check("basic_no_ready", {7'd0, in_ready}, 8'h00);

      // Positive and negative saturation.
      push4(8'h70, 8'h70, 8'h00);
      check_result("sat_pos", 8'h7F, 1'b1);
      push4(8'h90, 8'h10, 8'h00);
      check_result("sat_neg", 8'h80, 1'b1);

      // Floor rounding.
      push4(8'h01, 8'h01, 8'h00);
      check_result("floor_pos", 8'h00, 1'b0);
      push4(8'h01, 8'hFF, 8'h00);
      check_result("floor_neg", 8'hFF, 1'b0);
      push4(8'h00, 8'h37, 8'hF8);
      check_result("bias_only", 8'hF8, 1'b0);

      // Back-pressure with pulsed pairs that must be ignored.
      push4(8'h10, 8'h10, 8'h00);
      out_ready = 1'b0;
      check_result("bp_first", 8'h40, 1'b0);
      for (int i = 0; i < 5; i++) begin
         x_in = 8'h10; w_in = 8'h10; bias = 8'h00;
         in_valid = (i % 2) == 0;
         @(negedge clk);
         check("bp_valid", {7'd0, out_valid}, 8'h01);
         check("bp_z", z, 8'h40);
         check("bp_in_ready", {7'd0, in_ready}, 8'h00);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      push4(8'h10, 8'h08, 8'h00);
      check_result("bp_next", 8'h20, 1'b0);

      // Bias sampled only on the first pair; 2-cycle gaps between pairs.
      @(negedge clk);
      check("gap_ready", {7'd0, in_ready}, 8'h01);
      t0 = cyc;
      push(8'h10, 8'h10, 8'h10);
      for (int i = 0; i < 3; i++) begin
         idle_cycles(2);
         push(8'h10, 8'h10, 8'h70);
      end
      check_result("gap", 8'h50, 1'b0);
      check("gap_latency", 8'(cyc - t0), 8'd10);

      // Asynchronous reset after two of four pairs.
      push(8'h10, 8'h10, 8'h30);
      push(8'h10, 8'h10, 8'h30);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_in_ready", {7'd0, in_ready}, 8'h00);
      check("mid_rst_out_valid", {7'd0, out_valid}, 8'h00);
      check("mid_rst_z", z, 8'h00);
      check("mid_rst_state", {6'd0, dbg_state}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      push4(8'h10, 8'h10, 8'h00);
      check_result("after_rst", 8'h40, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
